bht_predictor: RTL and testbench

BHT_PREDICTOR -- requirements
Module: bht_predictor

---
 rtl/bht_predictor.sv | 109 ++++++++++
 tb/tb_bht_predictor.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_predictor.sv
// rtl/bht_predictor.sv - bimodal/gshare branch history table with next-PC prediction
module bht_predictor #(
    parameter int IDX_W = 8,
    parameter int CNT_W = 2,
    parameter int GHR_W = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rdy,
    input  logic [31:0] q_pc,
    input  logic [31:0] q_instr,
    output logic        q_ready,
    output logic        pred_taken,
    output logic [31:0] pred_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic        upd_mispredict,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_miss
);

    localparam int ENTRIES = 1 << IDX_W;
    // Keep the history register at least one bit wide; it simply stays zero in bimodal mode.
    localparam int GW = (GHR_W > 0) ? GHR_W : 1;
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    typedef enum logic {INIT, RUN} state_t;

    state_t           state;
    logic [IDX_W-1:0] sweep;
    logic [GW-1:0]    ghr;
    logic [CNT_W-1:0] cnt_tbl [ENTRIES];

    logic [IDX_W-1:0] hist;
    logic [IDX_W-1:0] q_idx;
    logic [IDX_W-1:0] u_idx;
    logic [CNT_W-1:0] q_cnt;
    logic [CNT_W-1:0] u_cnt;
    logic [CNT_W-1:0] u_next;
    logic [31:0]      imm_j;
    logic [31:0]      imm_b;
    logic [31:0]      pc_seq;
    logic             unused_bits;

    assign hist  = (GHR_W > 0) ? IDX_W'(ghr) : '0;
    assign q_idx = q_pc[IDX_W+1:2] ^ hist;
    assign u_idx = upd_pc[IDX_W+1:2] ^ hist;
    assign q_cnt = cnt_tbl[q_idx];
    assign u_cnt = cnt_tbl[u_idx];

    assign q_ready     = (state == RUN);
    assign unused_bits = ^{upd_pc[31:IDX_W+2], upd_pc[1:0]};

    assign imm_j  = {{11{q_instr[31]}}, q_instr[31], q_instr[19:12], q_instr[20],
                     q_instr[30:21], 1'b0};
    assign imm_b  = {{19{q_instr[31]}}, q_instr[31], q_instr[7], q_instr[30:25],
                     q_instr[11:8], 1'b0};
    assign pc_seq = q_pc + 32'd4;

    always_comb begin
        pred_taken = 1'b0;
        pred_pc    = pc_seq;
        if (state == RUN) begin
            if (q_instr[6:0] == OP_JAL) begin
                pred_taken = 1'b1;
                pred_pc    = q_pc + imm_j;
            end else if (q_instr[6:0] == OP_BR && q_cnt[CNT_W-1]) begin
                pred_taken = 1'b1;
                pred_pc    = q_pc + imm_b;
            end
        end
    end

    always_comb begin
        u_next = u_cnt;
        if (upd_taken) begin
            if (u_cnt != CNT_MAX) u_next = u_cnt + 1'b1;
        end else begin
            if (u_cnt != '0) u_next = u_cnt - 1'b1;
        end
    end

    // The table itself is never reset; the INIT sweep rewrites every entry after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= INIT;
            sweep         <= '0;
            ghr           <= '0;
            stat_branches <= '0;
            stat_miss     <= '0;
        end else if (rdy) begin
            if (state == INIT) begin
                cnt_tbl[sweep] <= CNT_WNT;
                sweep          <= sweep + 1'b1;
                if (sweep == '1) state <= RUN;
            end else if (upd_valid) begin
                cnt_tbl[u_idx] <= u_next;
                if (GHR_W > 0) ghr <= GW'({ghr, upd_taken});
                stat_branches <= stat_branches + 32'd1;
                if (upd_mispredict) stat_miss <= stat_miss + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_bht_predictor.sv
// tb/tb_bht_predictor.sv - bimodal and gshare instances checked against a table model
module tb_bht_predictor;

    localparam int K_BR = 0, K_JAL = 1, K_JALR = 2, K_OTH = 3;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rdy = 1'b1;
    logic [31:0] q_pc = 32'h0;
    logic [31:0] q_instr = 32'h13;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'h0;
    logic        upd_taken = 1'b0;
    logic        upd_mispredict = 1'b0;

    logic        b_ready, b_taken, g_ready, g_taken;
    logic [31:0] b_pc, b_br, b_miss, g_pc, g_br, g_miss;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit          m_init = 1'b1;
    int          m_ptr = 0;
    int          m_ghr = 0;
    int          m_tb [N];
    int          m_tg [N];
    logic [31:0] m_br = 0;
    logic [31:0] m_miss = 0;
    int          cur_kind = K_OTH;
    int          cur_imm = 0;

    always #5 clk = ~clk;

    bht_predictor #(.IDX_W(4), .CNT_W(2), .GHR_W(0)) dut_b (
        .clk(clk), .reset(reset), .rdy(rdy), .q_pc(q_pc), .q_instr(q_instr),
        .q_ready(b_ready), .pred_taken(b_taken), .pred_pc(b_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .stat_branches(b_br), .stat_miss(b_miss)
    );

    bht_predictor #(.IDX_W(4), .CNT_W(2), .GHR_W(2)) dut_g (
        .clk(clk), .reset(reset), .rdy(rdy), .q_pc(q_pc), .q_instr(q_instr),
        .q_ready(g_ready), .pred_taken(g_taken), .pred_pc(g_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .stat_branches(g_br), .stat_miss(g_miss)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int c, input logic t);
        if (t) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    function automatic void model_pred(input int cnt, output logic t, output logic [31:0] npc);
        t   = 1'b0;
        npc = q_pc + 32'd4;
        if (!m_init) begin
            if (cur_kind == K_JAL) begin
                t   = 1'b1;
                npc = q_pc + 32'(cur_imm);
            end else if (cur_kind == K_BR && cnt >= 2) begin
                t   = 1'b1;
                npc = q_pc + 32'(cur_imm);
            end
        end
    endfunction

    task automatic check_all();
        int          bi;
        logic        t;
        logic [31:0] npc;
        bi = int'((q_pc / 4) % N);
        model_pred(m_tb[bi], t, npc);
        chk("b_ready", {31'b0, b_ready}, {31'b0, !m_init});
        chk("b_taken", {31'b0, b_taken}, {31'b0, t});
        chk("b_pc", b_pc, npc);
        chk("b_br", b_br, m_br);
        chk("b_miss", b_miss, m_miss);
        model_pred(m_tg[bi ^ m_ghr], t, npc);
        chk("g_ready", {31'b0, g_ready}, {31'b0, !m_init});
        chk("g_taken", {31'b0, g_taken}, {31'b0, t});
        chk("g_pc", g_pc, npc);
        chk("g_br", g_br, m_br);
        chk("g_miss", g_miss, m_miss);
    endtask

    task automatic model_tick();
        int bi, gi;
        if (reset) begin
            m_init = 1'b1; m_ptr = 0; m_ghr = 0; m_br = 0; m_miss = 0;
        end else if (rdy) begin
            if (m_init) begin
                m_tb[m_ptr] = 1;
                m_tg[m_ptr] = 1;
                if (m_ptr == N - 1) m_init = 1'b0;
                m_ptr = (m_ptr + 1) % N;
            end else if (upd_valid) begin
                bi = int'((upd_pc / 4) % N);
                gi = bi ^ m_ghr;
                m_tb[bi] = sat(m_tb[bi], upd_taken);
                m_tg[gi] = sat(m_tg[gi], upd_taken);
                m_ghr = (m_ghr * 2 + int'(upd_taken)) % 4;
                m_br = m_br + 1;
                if (upd_mispredict) m_miss = m_miss + 1;
            end
        end
    endtask

    task automatic step(input bit do_chk);
        #1;
        if (do_chk) check_all();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_q(input int k, input logic [31:0] pc, input int imm);
        logic [31:0] r;
        logic [12:0] b;
        logic [20:0] j;
        r = $urandom;
        b = imm[12:0];
        j = imm[20:0];
        cur_kind = k;
        cur_imm  = imm;
        q_pc     = pc;
        case (k)
            K_BR:    q_instr = {b[12], b[10:5], r[24:20], r[19:15], r[14:12], b[4:1], b[11], 7'b1100011};
            K_JAL:   q_instr = {j[20], j[10:1], j[11], j[19:12], r[11:7], 7'b1101111};
            K_JALR:  q_instr = {r[31:20], r[19:15], 3'b000, r[11:7], 7'b1100111};
            default: q_instr = {r[31:7], 7'b0010011};
        endcase
    endtask

    task automatic set_u(input bit v, input logic [31:0] pc, input bit t, input bit mis);
        upd_valid = v; upd_pc = pc; upd_taken = t; upd_mispredict = mis;
    endtask

    task automatic reset_and_init();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            #1 chk("init_not_ready", {31'b0, b_ready}, 32'd0);
            step(1);
        end
        chk("init_done_ready", {31'b0, b_ready}, 32'd1);
    endtask

    initial begin
        // first edge: reset with an update pending, DUT state unknown until then
        set_u(1'b1, 32'h100, 1'b1, 1'b1);
        reset = 1'b1;
        step(0);
        set_u(1'b0, 32'h0, 1'b0, 1'b0);
        chk("reset_ready", {31'b0, b_ready}, 32'd0);
        chk("reset_branches", b_br, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            #1 chk("init_not_ready", {31'b0, g_ready}, 32'd0);
            step(1);
        end
        chk("init_done_ready", {31'b0, g_ready}, 32'd1);
        for (int i = 0; i < N; i++) begin
            set_q(K_BR, 32'h400 + 32'(4 * i), 8);
            step(1);
        end

        // two taken then saturating not-taken at 0x100
        set_q(K_BR, 32'h100, 8);
        set_u(1'b1, 32'h100, 1'b1, 1'b0);
        step(1);
        step(1);
        set_u(1'b0, 32'h0, 1'b0, 1'b0);
        #1 chk("br_taken", {31'b0, b_taken}, 32'd1);
        chk("br_target", b_pc, 32'h108);
        set_u(1'b1, 32'h100, 1'b0, 1'b0);
        repeat (4) step(1);
        set_u(1'b0, 32'h0, 1'b0, 1'b0);
        #1 chk("br_nt", {31'b0, b_taken}, 32'd0);
        chk("br_seq", b_pc, 32'h104);
        set_u(1'b1, 32'h100, 1'b1, 1'b0);
        step(1);
        set_u(1'b0, 32'h0, 1'b0, 1'b0);
        #1 chk("sat_low", {31'b0, b_taken}, 32'd0);

        // JAL wrap and JALR
        set_q(K_JAL, 32'hFFFF_FFFC, 8);
        #1 chk("jal_taken", {31'b0, b_taken}, 32'd1);
        chk("jal_wrap", b_pc, 32'h0000_0004);
        step(1);
        set_q(K_JALR, 32'h200, 0);
        #1 chk("jalr_taken", {31'b0, b_taken}, 32'd0);
        chk("jalr_pc", b_pc, 32'h204);
        step(1);

        // read-old on same-index update, then rdy=0 freeze
        set_q(K_BR, 32'h100, -16);
        set_u(1'b1, 32'h100, 1'b1, 1'b0);
        #1 chk("read_old", {31'b0, b_taken}, 32'd0);
        step(1);
        set_u(1'b0, 32'h0, 1'b0, 1'b0);
        #1 chk("read_new", {31'b0, b_taken}, 32'd1);
        chk("read_new_pc", b_pc, 32'h0F0);
        rdy = 1'b0;
        set_u(1'b1, 32'h100, 1'b0, 1'b1);
        step(1);
        step(1);
        #1 chk("rdy_hold", {31'b0, b_taken}, 32'd1);
        rdy = 1'b1;
        set_u(1'b0, 32'h0, 1'b0, 1'b0);
        step(1);

        // statistics
        reset_and_init();
        set_u(1'b1, 32'h300, 1'b1, 1'b1);
        step(1);
        set_u(1'b1, 32'h300, 1'b0, 1'b0);
        step(1);
        set_u(1'b1, 32'h304, 1'b1, 1'b1);
        step(1);
        set_u(1'b0, 32'h0, 1'b0, 1'b0);
        #1 chk("stat_branches", g_br, 32'd3);
        chk("stat_miss", g_miss, 32'd2);

        // gshare: history 2'b10 selects index 0^2 for the third update
        reset_and_init();
        set_u(1'b1, 32'h140, 1'b1, 1'b0);
        step(1);
        set_u(1'b1, 32'h140, 1'b0, 1'b0);
        step(1);
        set_u(1'b1, 32'h100, 1'b1, 1'b0);
        step(1);
        set_u(1'b0, 32'h0, 1'b0, 1'b0);
        set_q(K_BR, 32'h10C, 32);
        #1 chk("ghr_index", {31'b0, g_taken}, 32'd1);
        chk("ghr_target", g_pc, 32'h12C);
        set_q(K_BR, 32'h100, 8);
        #1 chk("bimodal_before", {31'b0, b_taken}, 32'd1);
        step(1);

        // reset in the middle of the sweep restarts it
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        repeat (5) step(1);
        reset_and_init();
        set_q(K_BR, 32'h100, 8);
        #1 chk("cleared_after_reinit", {31'b0, b_taken}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc;
            int          k;
            k  = int'($urandom_range(0, 3));
            pc = ($urandom_range(0, 7) == 0) ? {$urandom, 2'b00} >> 2 << 2
                                             : 32'h1000 + 32'(4 * $urandom_range(0, 31));
            if (k == K_JAL) set_q(k, pc, int'($urandom_range(0, (1 << 20) - 1)) * 2 - (1 << 20));
            else            set_q(k, pc, int'($urandom_range(0, 4095)) * 2 - 4096);
            set_u($urandom_range(0, 1) == 1, 32'h1000 + 32'(4 * $urandom_range(0, 31)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
            rdy   = ($urandom_range(0, 7) != 0);
            reset = ($urandom_range(0, 199) == 0);
            step(1);
        end
        reset = 1'b0;
        rdy   = 1'b1;
        set_u(1'b0, 32'h0, 1'b0, 1'b0);
        step(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
